// File: rtl/booth_pdt_accum.sv
// Multiply-accumulate back end: captures each Booth product on the rising edge of
// `over` and sums it into a wide signed accumulator. Define BOOTH_ACC_SAT_EN to clamp on overflow.
module booth_pdt_accum #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [15:0]      pdt,
   input  logic                    over,
   input  logic                    clr,
   output logic signed [ACC_W-1:0] acc,
   output logic                    acc_valid,
   output logic [CNT_W-1:0]        count,
   output logic                    ovf
);

   logic                    overDly_q, overDly_d;
   logic signed [15:0]      pReg_q, pReg_d;
   logic                    pVld_q, pVld_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    accValid_q, accValid_d;

   logic                    capture;
   logic signed [ACC_W-1:0] pExt;
   logic signed [ACC_W-1:0] sum;
   logic                    ovfNow;

`ifdef BOOTH_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   assign capture = over && !overDly_q;
   assign pExt    = ACC_W'(pReg_q);
   assign sum     = acc_q + pExt;
   assign ovfNow  = (acc_q[ACC_W-1] == pExt[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

   always_comb begin
      overDly_d  = over;
      pVld_d     = capture;
      pReg_d     = capture ? pdt : pReg_q;
      acc_d      = acc_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      accValid_d = 1'b0;
      // clr wins over the add stage but leaves the capture stage untouched
      if (clr) begin
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (pVld_q) begin
`ifdef BOOTH_ACC_SAT_EN
         if (ovfNow)
            acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
         else
            acc_d = sum;
`else
         acc_d = sum;
`endif
         if (count_q != {CNT_W{1'b1}})
            count_d = count_q + CNT_W'(1);
         ovf_d      = ovf_q | ovfNow;
         accValid_d = 1'b1;
      end
   end

   // overDly resets high so a level already present at release is not counted
   always_ff @(posedge clk) begin
      if (reset) begin
         overDly_q  <= 1'b1;
         pReg_q     <= '0;
         pVld_q     <= 1'b0;
         acc_q      <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         accValid_q <= 1'b0;
      end else begin
         overDly_q  <= overDly_d;
         pReg_q     <= pReg_d;
         pVld_q     <= pVld_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         accValid_q <= accValid_d;
      end
   end

   assign acc       = acc_q;
   assign acc_valid = accValid_q;
   assign count     = count_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/booth_pdt_accum.md
# booth_pdt_accum

Downstream consumer of the radix-4 Booth multiplier: it watches the multiplier's `over` done flag and captures each finished 16-bit signed product `pdt` exactly once. It sign-extends the product and adds it into a wide running accumulator through a two-stage capture/add pipeline. The block also keeps a product count and a sticky signed-overflow flag, so the multiplier plus this block form a sequential multiply-accumulate datapath.

## Interface
- `ACC_W`, 24: accumulator width in bits; must be ≥ 16.
- `CNT_W`, 8: product counter width in bits.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `pdt` input 16: signed product from the multiplier; valid while `over`=1.
- `over` input 1: multiplier done flag, a level held high until the multiplier is reset.
- `clr` input 1: synchronous clear of the accumulator, count and overflow flag.
- `acc` output ACC_W: signed running sum.
- `acc_valid` output 1: one-cycle pulse; `acc` has just absorbed a new product.
- `count` output CNT_W: number of products accumulated since reset or `clr`.
- `ovf` output 1: sticky flag; signed overflow occurred on some add.

## Operation
- `over_d` is a registered copy of `over`.
- Capture event = `over`=1 and `over_d`=0, i.e. the rising edge of `over`. A level held high is counted once.
- Stage 1 (capture): on a capture event, `p_reg` <= `pdt` and `p_vld` <= 1. Otherwise `p_vld` <= 0.
- Stage 2 (add): when `p_vld`=1:
  - `acc` <= `acc` + sext(`p_reg`, ACC_W).
  - `count` <= `count`+1, saturating at 2^CNT_W−1 with no wrap.
  - `acc_valid` <= 1.
  - Otherwise `acc_valid` <= 0.
- Overflow: both operands have the same sign and the sum has the opposite sign. This sets `ovf`, which stays at 1 until `reset` or `clr`.
- `clr`, priority over stage 2:
  - `acc`, `count`, `ovf` and `acc_valid` go to 0.
  - An in-flight `p_vld` product is discarded.
  - A capture event in the same cycle is still taken into stage 1, so it accumulates into the cleared sum.
- Reset values:
  - `acc`=0, `count`=0, `ovf`=0, `acc_valid`=0, `p_vld`=0, `p_reg`=0.
  - `over_d`=1, so an `over` already high at reset release is not counted as a new product.
- Reset mid-pipeline: a pending `p_vld` is dropped and nothing is added.
- Back-to-back products: an `over` rising edge may arrive every 2 cycles (fall then rise). Both stages are single-cycle, so no product is lost.

## Timing
- Edge E0: first edge at which `over`=1 with `over_d`=0. Stage 1 captures `pdt`.
- Edge E1: `acc`, `count` and `ovf` update. `acc_valid` is high from E1 to E2.
- Latency from `over` first sampled high to updated `acc`: 2 edges.
- `pdt` only needs to be stable at E0. Later changes to `pdt` are ignored.
- `clr` takes effect at the edge where it is sampled high. Outputs read 0 from that edge onward.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- `BOOTH_ACC_SAT_EN` defined: on signed overflow, `acc` clamps instead of taking the wrapped sum:
  - to 2^(ACC_W−1)−1 on positive overflow;
  - to −2^(ACC_W−1) on negative overflow.
  - `ovf` is set as usual.
- Not defined: `acc` wraps modulo 2^ACC_W and `ovf` is still set.
- Pipeline timing is identical in both builds.

## Test plan
- Default params. Products 351, −175, −306, 627, 0, −144, each presented as an `over` rising edge with ≥2 idle cycles between. Required: `acc` steps 351, 176, −130, 497, 497, 353; `count`=6; six single-cycle `acc_valid` pulses, each 2 edges after its `over` rise; `ovf`=0.
- Hold `over`=1 for 20 cycles with `pdt`=351. Required: exactly one add, `count`=1, `acc`=351.
- ACC_W=16. Add 16'h7FFF twice. Without `BOOTH_ACC_SAT_EN`: `acc`=16'hFFFE, `ovf`=1. With the macro: `acc`=16'h7FFF, `ovf`=1. Then assert `clr`: `acc`=0, `ovf`=0, `count`=0.
- Start from `acc`=351. Assert `clr` in the same cycle as an `over` rise with `pdt`=−175. Required, one edge later: `acc`=−175, `count`=1.
- Assert `reset` on the edge right after a capture (`p_vld`=1) with `over` still high. Required: `acc`=0 and `count`=0 after reset, no `acc_valid` pulse, and no capture until `over` falls and rises again.
- Default params. 300 products of +1 each. Required: `count` stops at 255; `acc`=300.
